// File: rtl/br_fifo_ctrl_1r1w.sv
// FIFO controller for an external 1R1W RAM (zero-cycle read, one-cycle write), with optional
// empty-FIFO cut-through. Define BR_FIFO_CTRL_INTG_CHECKS_EN to compile in integrity assertions.

module br_fifo_ctrl_1r1w #(
   parameter int Depth        = 2,
   parameter int Width        = 1,
   parameter bit EnableBypass = 1'b1,
   localparam int AddrWidth   = $clog2(Depth),
   localparam int CountWidth  = $clog2(Depth + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  push_ready,
   input  logic                  push_valid,
   input  logic [Width-1:0]      push_data,
   input  logic                  pop_ready,
   output logic                  pop_valid,
   output logic [Width-1:0]      pop_data,
   output logic                  full,
   output logic                  empty,
   output logic [CountWidth-1:0] items,
   output logic [CountWidth-1:0] slots,
   output logic                  ram_wr_valid,
   output logic [AddrWidth-1:0]  ram_wr_addr,
   output logic [Width-1:0]      ram_wr_data,
   output logic                  ram_rd_addr_valid,
   output logic [AddrWidth-1:0]  ram_rd_addr,
   input  logic                  ram_rd_data_valid,
   input  logic [Width-1:0]      ram_rd_data
);

   localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);
   localparam logic [AddrWidth-1:0]  LastAddr   = AddrWidth'(Depth - 1);

   logic [AddrWidth-1:0]  r_wr_ptr;
   logic [AddrWidth-1:0]  r_rd_ptr;
   logic [CountWidth-1:0] r_items;
   logic [CountWidth-1:0] w_items_next;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_bypass;
   logic                  w_ram_push;
   logic                  w_ram_pop;

   // Pointers wrap explicitly so non-power-of-2 depths work.
   function automatic logic [AddrWidth-1:0] f_ptr_inc(input logic [AddrWidth-1:0] ptr);
      if (ptr == LastAddr) begin
         return {AddrWidth{1'b0}};
      end else begin
         return ptr + AddrWidth'(1'b1);
      end
   endfunction

   assign w_empty    = (r_items == {CountWidth{1'b0}});
   assign w_full     = (r_items == DepthCount);
   assign push_ready = !w_full;
   assign w_push     = push_valid && !w_full;

   // Empty FIFO either cuts the push straight through or shows nothing.
   always_comb begin
      w_bypass  = 1'b0;
      pop_valid = 1'b0;
      pop_data  = ram_rd_data;
      if (w_empty) begin
         if (EnableBypass) begin
            w_bypass  = push_valid && pop_ready;
            pop_valid = push_valid;
            pop_data  = push_data;
         end else begin
            w_bypass  = 1'b0;
            pop_valid = 1'b0;
            pop_data  = ram_rd_data;
         end
      end else begin
         pop_valid = ram_rd_data_valid;
         pop_data  = ram_rd_data;
      end
   end

   assign w_pop      = pop_valid && pop_ready;
   assign w_ram_pop  = w_pop && !w_empty;
   assign w_ram_push = w_push && !w_bypass;

   assign ram_wr_valid      = w_ram_push;
   assign ram_wr_addr       = r_wr_ptr;
   assign ram_wr_data       = push_data;
   assign ram_rd_addr_valid = !w_empty;
   assign ram_rd_addr       = r_rd_ptr;

   assign full  = w_full;
   assign empty = w_empty;
   assign items = r_items;
   assign slots = DepthCount - r_items;

   // Occupancy update; a bypass touches neither RAM nor count.
   always_comb begin
      w_items_next = r_items;
      if (w_ram_push && !w_ram_pop) begin
         w_items_next = r_items + CountWidth'(1'b1);
      end else if (!w_ram_push && w_ram_pop) begin
         w_items_next = r_items - CountWidth'(1'b1);
      end else begin
         w_items_next = r_items;
      end
   end

   // Pointer and occupancy state; reset discards contents without touching the RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= {AddrWidth{1'b0}};
         r_rd_ptr <= {AddrWidth{1'b0}};
         r_items  <= {CountWidth{1'b0}};
      end else begin
         r_items <= w_items_next;
         if (w_ram_push) begin
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_ram_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
      end
   end

`ifdef BR_FIFO_CTRL_INTG_CHECKS_EN
   br_fifo_ctrl_1r1w_checks #(
      .Depth      (Depth),
      .Width      (Width),
      .CountWidth (CountWidth)
   ) u_checks (
      .clk               (clk),
      .rst               (rst),
      .push_valid        (push_valid),
      .push_ready        (push_ready),
      .push_data         (push_data),
      .ram_rd_addr_valid (ram_rd_addr_valid),
      .ram_rd_data_valid (ram_rd_data_valid),
      .items             (r_items)
   );
`endif

endmodule

`ifdef BR_FIFO_CTRL_INTG_CHECKS_EN
module br_fifo_ctrl_1r1w_checks #(
   parameter int Depth      = 2,
   parameter int Width      = 1,
   parameter int CountWidth = 2
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  push_valid,
   input logic                  push_ready,
   input logic [Width-1:0]      push_data,
   input logic                  ram_rd_addr_valid,
   input logic                  ram_rd_data_valid,
   input logic [CountWidth-1:0] items
);

   a_push_hold: assert property (@(posedge clk) disable iff (rst)
      push_valid && !push_ready |=> push_valid && $stable(push_data));

   a_rd_latency: assert property (@(posedge clk) disable iff (rst)
      ram_rd_addr_valid |-> ram_rd_data_valid);

   a_items_max: assert property (@(posedge clk) disable iff (rst)
      items <= CountWidth'(Depth));

endmodule
`endif

// File: tb/tb_br_fifo_ctrl_1r1w.sv
// Scoreboard bench: one bypass and one non-bypass FIFO share stimulus, each checked against a
// queue-level model; a negedge monitor pops expected status and data and compares.

module tb_br_fifo_ctrl_1r1w;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push_valid = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       pop_ready = 1'b0;

   logic       d0_push_ready, d0_pop_valid, d0_full, d0_empty, d0_wr_v, d0_rd_av, d0_rd_dv;
   logic [7:0] d0_pop_data, d0_wr_data, d0_rd_data;
   logic [2:0] d0_items, d0_slots;
   logic [1:0] d0_wr_addr, d0_rd_addr;
   logic       d1_push_ready, d1_pop_valid, d1_full, d1_empty, d1_wr_v, d1_rd_av, d1_rd_dv;
   logic [7:0] d1_pop_data, d1_wr_data, d1_rd_data;
   logic [2:0] d1_items, d1_slots;
   logic [1:0] d1_wr_addr, d1_rd_addr;

   logic [7:0] mem0 [4];
   logic [7:0] mem1 [4];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int items;
      int slots;
      bit full;
      bit empty;
      bit push_ready;
      bit pop_valid;
      bit wr_v;
      bit rd_av;
   } st_t;

   st_t        stq0[$];
   st_t        stq1[$];
   logic [7:0] sb0[$];
   logic [7:0] sb1[$];
   int         n[2];
   bit         last_blocked = 1'b0;

   always #5 clk = ~clk;

   br_fifo_ctrl_1r1w #(.Depth(4), .Width(8), .EnableBypass(1'b1)) u_dut0 (
      .clk(clk), .rst(rst),
      .push_ready(d0_push_ready), .push_valid(push_valid), .push_data(push_data),
      .pop_ready(pop_ready), .pop_valid(d0_pop_valid), .pop_data(d0_pop_data),
      .full(d0_full), .empty(d0_empty), .items(d0_items), .slots(d0_slots),
      .ram_wr_valid(d0_wr_v), .ram_wr_addr(d0_wr_addr), .ram_wr_data(d0_wr_data),
      .ram_rd_addr_valid(d0_rd_av), .ram_rd_addr(d0_rd_addr),
      .ram_rd_data_valid(d0_rd_dv), .ram_rd_data(d0_rd_data)
   );

   br_fifo_ctrl_1r1w #(.Depth(4), .Width(8), .EnableBypass(1'b0)) u_dut1 (
      .clk(clk), .rst(rst),
      .push_ready(d1_push_ready), .push_valid(push_valid), .push_data(push_data),
      .pop_ready(pop_ready), .pop_valid(d1_pop_valid), .pop_data(d1_pop_data),
      .full(d1_full), .empty(d1_empty), .items(d1_items), .slots(d1_slots),
      .ram_wr_valid(d1_wr_v), .ram_wr_addr(d1_wr_addr), .ram_wr_data(d1_wr_data),
      .ram_rd_addr_valid(d1_rd_av), .ram_rd_addr(d1_rd_addr),
      .ram_rd_data_valid(d1_rd_dv), .ram_rd_data(d1_rd_data)
   );

   // Flop RAMs, deliberately not reset, zero-cycle read.
   initial begin
      for (int i = 0; i < 4; i++) begin
         mem0[i] = 8'hEE;
         mem1[i] = 8'hEE;
      end
   end
   always @(posedge clk) begin
      if (d0_wr_v) mem0[d0_wr_addr] <= d0_wr_data;
      if (d1_wr_v) mem1[d1_wr_addr] <= d1_wr_data;
   end
   assign d0_rd_data = mem0[d0_rd_addr];
   assign d0_rd_dv   = d0_rd_av;
   assign d1_rd_data = mem1[d1_rd_addr];
   assign d1_rd_dv   = d1_rd_av;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an occupancy count per FIFO plus the ordered list of accepted pushes.
   task automatic drive(input bit pv, input logic [7:0] pd, input bit pr, input bit rs);
      push_valid = pv;
      push_data  = pd;
      pop_ready  = pr;
      rst        = rs;
      for (int k = 0; k < 2; k++) begin
         st_t s;
         bit  byp_en, pacc, popacc, byp;
         byp_en       = (k == 0);
         s.items      = n[k];
         s.slots      = 4 - n[k];
         s.full       = (n[k] == 4);
         s.empty      = (n[k] == 0);
         s.push_ready = (n[k] != 4);
         s.pop_valid  = (n[k] > 0) ? 1'b1 : (byp_en && pv);
         s.rd_av      = (n[k] > 0);
         pacc         = pv && s.push_ready;
         popacc       = s.pop_valid && pr;
         byp          = byp_en && (n[k] == 0) && pv && pr;
         s.wr_v       = pacc && !byp;
         if (k == 0) stq0.push_back(s); else stq1.push_back(s);
         if (pacc) begin
            if (k == 0) sb0.push_back(pd); else sb1.push_back(pd);
         end
         if (rs) n[k] = 0;
         else n[k] = n[k] + ((pacc && !byp) ? 1 : 0) - ((popacc && n[k] > 0) ? 1 : 0);
      end
      last_blocked = pv && (n[0] == 4 || n[1] == 4);
      @(posedge clk);
      #1;
      if (rs) begin
         sb0.delete();
         sb1.delete();
      end
   endtask

   task automatic mon(input int k);
      st_t        s;
      logic [2:0] it, sl;
      logic       fu, em, prd, pvl, wv, rav;
      logic [7:0] pdat;
      string      p;
      p = (k == 0) ? "byp" : "nobyp";
      if (k == 0) begin
         if (stq0.size() == 0) return;
         s = stq0.pop_front();
         it = d0_items; sl = d0_slots; fu = d0_full; em = d0_empty; prd = d0_push_ready;
         pvl = d0_pop_valid; wv = d0_wr_v; rav = d0_rd_av; pdat = d0_pop_data;
      end else begin
         if (stq1.size() == 0) return;
         s = stq1.pop_front();
         it = d1_items; sl = d1_slots; fu = d1_full; em = d1_empty; prd = d1_push_ready;
         pvl = d1_pop_valid; wv = d1_wr_v; rav = d1_rd_av; pdat = d1_pop_data;
      end
      chk({p, "_items"}, 32'(it), 32'(s.items));
      chk({p, "_slots"}, 32'(sl), 32'(s.slots));
      chk({p, "_full"}, 32'(fu), 32'(s.full));
      chk({p, "_empty"}, 32'(em), 32'(s.empty));
      chk({p, "_push_ready"}, 32'(prd), 32'(s.push_ready));
      chk({p, "_pop_valid"}, 32'(pvl), 32'(s.pop_valid));
      chk({p, "_ram_wr_valid"}, 32'(wv), 32'(s.wr_v));
      chk({p, "_ram_rd_addr_valid"}, 32'(rav), 32'(s.rd_av));
      if (pvl === 1'b1 && pop_ready === 1'b1) begin
         if (k == 0 && sb0.size() > 0) chk({p, "_pop_data"}, 32'(pdat), 32'(sb0.pop_front()));
         else if (k == 1 && sb1.size() > 0) chk({p, "_pop_data"}, 32'(pdat), 32'(sb1.pop_front()));
         else begin
            checks++;
            errors++;
            $display("FAIL %s_pop_data unexpected pop actual=%0h required=none", p, pdat);
         end
      end
   endtask

   // Monitor: compares on the falling edge, away from input changes.
   always @(negedge clk) begin
      if (mon_en) begin
         mon(0);
         mon(1);
      end
   end

   initial begin
      bit         pv;
      logic [7:0] pd;
      n[0] = 0;
      n[1] = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      // Fill to full, then a refused fifth push.
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 8'h22, 1'b0, 1'b0);
      drive(1'b1, 8'h33, 1'b0, 1'b0);
      drive(1'b1, 8'h44, 1'b0, 1'b0);
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      // Drain in order.
      for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      // Wrap-around with occupancy held at one.
      drive(1'b1, 8'hA0, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) drive(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      // Bypass vs no-bypass on an empty FIFO.
      drive(1'b1, 8'hAB, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      // Reset with three entries held.
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      drive(1'b1, 8'h02, 1'b0, 1'b0);
      drive(1'b1, 8'h03, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      // Randomized traffic with occasional resets; a refused push is held until taken.
      for (int i = 0; i < 600; i++) begin
         if (last_blocked) begin
            pv = 1'b1;
            pd = push_data;
            drive(pv, pd, 1'($urandom_range(0, 1)), 1'b0);
         end else if ($urandom_range(0, 59) == 0) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
         end else begin
            pv = 1'($urandom_range(0, 1));
            pd = 8'($urandom_range(0, 255));
            drive(pv, pd, ($urandom_range(0, 2) != 0), 1'b0);
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
